// File: rtl/matvec_row_sequencer.sv
// Row sequencer for the pipelined dot-product unit: holds the matrix, latches x,
// and drives one clear/enable/flag handshake per row, streaming out y = M*x.
module matvec_row_sequencer #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned MATSIZE  = 16,
  parameter int unsigned NROWS    = 16,
  parameter int unsigned TIMEOUT  = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_en,
  input  logic [$clog2(NROWS)-1:0]            wr_row,
  input  logic signed [MATSIZE*BITWIDTH-1:0]  wr_data,
  input  logic signed [MATSIZE*BITWIDTH-1:0]  x_in,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic signed [MATSIZE*BITWIDTH-1:0]  k_out,
  output logic signed [MATSIZE*BITWIDTH-1:0]  x_out,
  output logic                                cen_out,
  output logic                                valid_out,
  input  logic                                flag_in,
  input  logic signed [BITWIDTH-1:0]          y_in,
  output logic                                res_valid,
  output logic [$clog2(NROWS)-1:0]            res_idx,
  output logic signed [BITWIDTH-1:0]          res_data
);

  localparam int unsigned IW = $clog2(NROWS);
  localparam int unsigned VW = MATSIZE * BITWIDTH;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          r_q, r_d;
  logic [TW-1:0]          t_q, t_d;
  logic                   err_q, err_d;
  logic signed [VW-1:0]   x_q, x_d;
  logic signed [VW-1:0]   k_q, k_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   cen_q, cen_d;
  logic                   valid_q, valid_d;
  logic                   res_valid_q, res_valid_d;
  logic [IW-1:0]          res_idx_q, res_idx_d;
  logic signed [BITWIDTH-1:0] res_data_q, res_data_d;
  logic                   wr_ok;

  logic signed [VW-1:0]   row_q [NROWS];

  assign wr_ok = wr_en && (state_q == S_IDLE);

  // Row store: writable only while idle, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      row_q[wr_row] <= wr_data;
    end
  end

  // Next state and registered-output values
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    t_d        = t_q;
    err_d      = err_q;
    x_d        = x_q;
    k_d        = k_q;
    res_idx_d  = res_idx_q;
    res_data_d = res_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x_in;
          r_d     = '0;
          err_d   = 1'b0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        t_d     = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        t_d = t_q + TW'(1);
        // flags in the first two RUN cycles belong to the previous row's pipeline
        if (flag_in && (t_q >= TW'(2))) begin
          res_idx_d  = r_q;
          res_data_d = y_in;
          state_d    = S_CAPTURE;
        end else if (t_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_CAPTURE: begin
        if (r_q == IW'(NROWS - 1)) begin
          state_d = S_DONE;
        end else begin
          r_d     = r_q + IW'(1);
          state_d = S_CLEAR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A write coinciding with start must be visible to the first row
    if (state_d == S_CLEAR) begin
      k_d = (wr_ok && (wr_row == r_d)) ? wr_data : row_q[r_d];
    end

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    cen_d       = (state_d == S_RUN);
    valid_d     = (state_d == S_CLEAR);
    res_valid_d = (state_d == S_CAPTURE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      t_q         <= '0;
      err_q       <= 1'b0;
      x_q         <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cen_q       <= 1'b0;
      valid_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      t_q         <= t_d;
      err_q       <= err_d;
      x_q         <= x_d;
      k_q         <= k_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cen_q       <= cen_d;
      valid_q     <= valid_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign k_out     = k_q;
  assign x_out     = x_q;
  assign cen_out   = cen_q;
  assign valid_out = valid_q;
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign res_data  = res_data_q;

endmodule
